// File: rtl/seq_detect_ctrl_if.sv
// Requester/config/result bundle for the shared serial pattern detector.
// master = requester/config side, slave = detector controller side.
interface seq_detect_ctrl_if #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;
  logic                   cfg_we;
  logic [PAT_W-1:0]       cfg_pattern;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       match_cnt;
  logic                   match_any;

  modport master (
    output req, req_data, cfg_we, cfg_pattern,
    input  gnt, busy, done, done_id, match_cnt, match_any
  );

  modport slave (
    input  req, req_data, cfg_we, cfg_pattern,
    output gnt, busy, done, done_id, match_cnt, match_any
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Round-robin arbiter in front of one time-shared, runtime-programmable
// serial pattern detector; counts overlapping matches in each granted word.
module seq_detect_ctrl #(
  parameter int               NREQ    = 4,
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  seq_detect_ctrl_if.slave  bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e             state_q;
  logic [PAT_W-1:0]   pattern_q;
  logic [ID_W-1:0]    last_id_q;
  logic [ID_W-1:0]    id_q;
  logic [WORD_W-1:0]  sreg_q;
  logic [PAT_W-1:0]   win_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NREQ-1:0]    gnt_q;
  logic               busy_q;
  logic               done_q;
  logic [ID_W-1:0]    done_id_q;
  logic [CNT_W-1:0]   match_cnt_q;
  logic               match_any_q;

  logic               req_any;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    idx;
  logic [PAT_W:0]     win_ext;
  logic [PAT_W-1:0]   win_d;
  logic               hit;
  logic [CNT_W-1:0]   cnt_d;

  // Search starts one past the last served requester, wrapping at NREQ.
  always_comb begin
    req_any = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = ID_W'((32'(last_id_q) + i) % NREQ);
      if (!req_any && bus.req[idx]) begin
        req_any = 1'b1;
        win_id  = idx;
      end
    end
  end

  // Window after this cycle's bit; the final bit's match is folded into
  // the published count on the same edge that enters DONE.
  always_comb begin
    win_ext = {win_q, sreg_q[WORD_W-1]};
    win_d   = win_ext[PAT_W-1:0];
    hit     = (bitcnt_q >= CNT_W'(PAT_W - 1)) && (win_d == pattern_q);
    cnt_d   = cnt_q + CNT_W'(hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pattern_q   <= PAT_RST;
      last_id_q   <= ID_W'(NREQ - 1);
      id_q        <= '0;
      sreg_q      <= '0;
      win_q       <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      match_any_q <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_we) begin
            pattern_q <= bus.cfg_pattern;
          end else if (req_any) begin
            sreg_q   <= bus.req_data[win_id*WORD_W +: WORD_W];
            id_q     <= win_id;
            win_q    <= '0;
            bitcnt_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= NREQ'(1) << win_id;
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg_q   <= sreg_q << 1;
          win_q    <= win_d;
          cnt_q    <= cnt_d;
          bitcnt_q <= bitcnt_q + CNT_W'(1);
          if (bitcnt_q == CNT_W'(WORD_W - 1)) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            done_id_q   <= id_q;
            match_cnt_q <= cnt_d;
            match_any_q <= (cnt_d != '0);
          end
        end
        S_DONE: begin
          last_id_q <= id_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.match_any = match_any_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: table of single-word transactions plus
// hand-written config-priority, reset-mid-shift and round-robin sequences.
module tb_seq_detect_ctrl;
  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  seq_detect_ctrl_if #(.NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W)) bus ();

  seq_detect_ctrl #(
    .NREQ(NREQ), .WORD_W(WORD_W), .PAT_W(PAT_W), .PAT_RST(4'b1011)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit         do_cfg;
    logic [3:0] pat;
    int         id;
    logic [7:0] word;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},       int'(bus.gnt), 0);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_done"},      int'(bus.done), 0);
    chk({tag, "_done_id"},   int'(bus.done_id), 0);
    chk({tag, "_match_cnt"}, int'(bus.match_cnt), 0);
    chk({tag, "_match_any"}, int'(bus.match_any), 0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.req    = '0;
    bus.cfg_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] pat);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = pat;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge
  // that brings it back to IDLE.
  task automatic run_word(input int id, input logic [7:0] w, input int exp_cnt,
                          input bit cfg_mid);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    bus.req_data = '0;
    bus.req_data[id*WORD_W +: WORD_W] = w;
    bus.req = 4'(1 << id);
    @(posedge clk);
    #1;
    chk("gnt_onehot", int'(bus.gnt), 1 << id);
    chk("busy_shift", int'(bus.busy), 1);
    bus.req = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      if (cfg_mid && c == 3) begin
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = 4'b0000;
      end
      if (cfg_mid && c == 4) bus.cfg_we = 1'b0;
      @(posedge clk);
      #1;
      if (c == 1) chk("gnt_pulse", int'(bus.gnt), 0);
      if (bus.done) begin
        got = 1'b1;
        n   = c;
      end
    end
    bus.cfg_we = 1'b0;
    chk("done_seen", int'(got), 1);
    if (got) begin
      chk("done_cycle", n + 1, WORD_W + 1);
      chk("done_busy", int'(bus.busy), 1);
      chk("done_id", int'(bus.done_id), id);
      chk("match_cnt", int'(bus.match_cnt), exp_cnt);
      chk("match_any", int'(bus.match_any), (exp_cnt != 0) ? 1 : 0);
      @(posedge clk);
      #1;
      chk("done_pulse", int'(bus.done), 0);
      chk("idle_busy", int'(bus.busy), 0);
      chk("held_cnt", int'(bus.match_cnt), exp_cnt);
    end
  endtask

  // All requesters high; each drops req on its own gnt, re-raises next cycle.
  task automatic rr_run();
    int order[$];
    int times[$];
    int gid;
    bus.req = 4'b1111;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      @(negedge clk);
      if (|bus.gnt) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (bus.gnt[k]) gid = k;
        order.push_back(gid);
        times.push_back(cyc);
      end
      bus.req = ~bus.gnt;
    end
    bus.req = '0;
    chk("rr_count", order.size(), 5);
    for (int i = 0; i < order.size(); i++) begin
      chk("rr_order", order[i], i % NREQ);
      if (i > 0) chk("rr_spacing", times[i] - times[i-1], WORD_W + 2);
    end
    for (int c = 0; c < 20 && bus.busy; c++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("rr_idle", int'(bus.busy), 0);
  endtask

  initial begin
    bit seen;
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.req         = '0;
    bus.req_data    = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = '0;

    vecs[0] = '{1'b0, 4'b0000, 0, 8'b10110110, 2};
    vecs[1] = '{1'b0, 4'b0000, 1, 8'h00,       0};
    vecs[2] = '{1'b0, 4'b0000, 2, 8'b00000101, 0};
    vecs[3] = '{1'b0, 4'b0000, 3, 8'b10000000, 0};
    vecs[4] = '{1'b0, 4'b0000, 0, 8'b11011011, 2};
    vecs[5] = '{1'b1, 4'b1111, 1, 8'hFF,       5};
    vecs[6] = '{1'b0, 4'b0000, 2, 8'hF0,       1};
    vecs[7] = '{1'b1, 4'b0000, 3, 8'h00,       5};
    vecs[8] = '{1'b1, 4'b0101, 0, 8'b01010101, 3};
    vecs[9] = '{1'b1, 4'b1001, 1, 8'b10011001, 2};

    do_reset();

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_cfg) cfg_write(vecs[v].pat);
      run_word(vecs[v].id, vecs[v].word, vecs[v].exp_cnt, 1'b0);
    end

    // cfg_we wins over a pending request; no grant in that cycle.
    bus.req_data = '0;
    bus.req_data[2*WORD_W +: WORD_W] = 8'hFF;
    bus.req         = 4'b0100;
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = 4'b1111;
    @(posedge clk);
    #1;
    chk("cfg_no_gnt", int'(bus.gnt), 0);
    chk("cfg_no_busy", int'(bus.busy), 0);
    bus.cfg_we = 1'b0;
    run_word(2, 8'hFF, 5, 1'b1);
    run_word(2, 8'hFF, 5, 1'b0);

    // Reset at SHIFT cycle 4: outputs clear at once, no done follows.
    bus.req_data = '0;
    bus.req_data[1*WORD_W +: WORD_W] = 8'b10110110;
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    chk("mid_gnt", int'(bus.gnt), 4'b0010);
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("mid_no_done", int'(seen), 0);

    // Priority restarts at requester 0 after reset.
    bus.req_data = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    rr_run();
    chk("rr_last_cnt", int'(bus.match_cnt), 0);
    chk("rr_last_id", int'(bus.done_id), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
